aes_round_ctrl: RTL

//  Sequencer for the registered AES-128 round core (1-cycle latency: SubBytes/ShiftRows/MixColumns/AddRoundKey).

---
 rtl/aes_pkg.sv | 74 +++++++
 rtl/aes_key_step.sv | 27 ++
 rtl/aes_round_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the round controller: widths, the FSM
// encoding, and the byte-level helpers used by the key schedule and the
// local final round.
package aes_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int AES_NR  = 10;

    localparam logic [BYTE_W-1:0] RCON_FIRST = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } ctrl_state_t;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
        return SBOX_TAB[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key expansion: produces the next round key from the
// current one and the round constant.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] rk,
    input  logic [BYTE_W-1:0]  rcon,
    output logic [BLOCK_W-1:0] nk
);

    logic [WORD_W-1:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

    // RotWord/SubWord/rcon on the last word, then chain XOR across the words.
    always_comb begin
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        nk = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer. Takes one plaintext/key, does the initial
// AddRoundKey, drives NROUNDS-1 full rounds through the external round core,
// and finishes the last round (no MixColumns) locally.
//
//  state | meaning
//  IDLE  | in_ready high, waiting for a block
//  ISSUE | rnd_state/rnd_key presented to the core for one cycle
//  WAIT  | counting down core latency, captures rnd_out on exit
//  FINAL | SubBytes/ShiftRows/AddRoundKey of the last round
//  DONE  | ciphertext offered on out_*, held until out_ready
//
// rnd_state/rnd_key and the rk/rcon registers are loaded on the edge that
// enters ISSUE, so the core sees stable operands for the whole ISSUE cycle
// and its registered result is ready after RND_LAT cycles.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NROUNDS = AES_NR,
    parameter int RND_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_pt,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_ct,
    output logic [BLOCK_W-1:0] rnd_state,
    output logic [BLOCK_W-1:0] rnd_key,
    input  logic [BLOCK_W-1:0] rnd_out,
    output logic               busy
);

    ctrl_state_t        state;
    logic [BLOCK_W-1:0] st;
    logic [BLOCK_W-1:0] rk;
    logic [BYTE_W-1:0]  rcon;
    logic [3:0]         rnd_cnt;
    logic [1:0]         wait_cnt;

    logic [BLOCK_W-1:0] ks_rk;
    logic [BYTE_W-1:0]  ks_rcon;
    logic [BLOCK_W-1:0] ks_nk;
    logic [BLOCK_W-1:0] final_st;

    // Single key-step instance: fed from the cipher key while idle, otherwise from rk.
    always_comb begin
        ks_rk    = (state == S_IDLE) ? in_key : rk;
        ks_rcon  = (state == S_IDLE) ? RCON_FIRST : rcon;
        final_st = shift_rows(sub_bytes(st)) ^ ks_nk;
    end

    aes_key_step u_key_step (
        .rk   (ks_rk),
        .rcon (ks_rcon),
        .nk   (ks_nk)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            st        <= '0;
            rk        <= '0;
            rcon      <= '0;
            rnd_cnt   <= '0;
            wait_cnt  <= '0;
            rnd_state <= '0;
            rnd_key   <= '0;
            out_ct    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        st        <= in_pt ^ in_key;
                        rnd_state <= in_pt ^ in_key;
                        rnd_key   <= ks_nk;
                        rk        <= ks_nk;
                        rcon      <= xtime(RCON_FIRST);
                        rnd_cnt   <= 4'd1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= 2'(RND_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else begin
                        st <= rnd_out;
                        if (rnd_cnt == 4'(NROUNDS - 1)) begin
                            state <= S_FINAL;
                        end else begin
                            rnd_cnt   <= rnd_cnt + 4'd1;
                            rnd_state <= rnd_out;
                            rnd_key   <= ks_nk;
                            rk        <= ks_nk;
                            rcon      <= xtime(rcon);
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_FINAL: begin
                    st    <= final_st;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_ct    <= st;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
